// File: rtl/clk_rate_multiplier.sv
// Digital clock multiplier: regenerates a clock at 2^LOG2_MULT times the rate of ref_in.
// Latency: ref_in rising sampled at edge k -> clk_out high and period updated at edge k+2.
// No backpressure: free-running outputs; loss of reference re-arms the measurement.
module clk_rate_multiplier #(
  parameter int LOG2_MULT = 6,
  parameter int CNT_W     = 16,
  parameter int LOCK_TOL  = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             ref_in,
  output logic             clk_out,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             too_fast,
  output logic             lost
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL     = CNT_W'(LOCK_TOL);

  // reference synchronizer and edge-detect delay
  logic s1_q, s2_q, s2d_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             clk_q, clk_d;
  logic             locked_q, locked_d;
  logic             too_fast_q, too_fast_d;
  logic             lost_q, lost_d;

  logic             rise;
  logic [CNT_W-1:0] p_new, h_new, h_cur, diff, cnt_inc;
  logic             h_new_ok, in_tol, sat_hit, tcnt_wrap;

  assign rise      = s2_q & ~s2d_q;
  // Counter holds cycles since the last rise, so the period including this edge is cnt+1.
  assign p_new     = cnt_q + ONE;
  // Half-period of the output; remainder is dropped and absorbed by re-phasing at each rise.
  assign h_new     = p_new >> (LOG2_MULT + 1);
  assign h_cur     = period_q >> (LOG2_MULT + 1);
  assign h_new_ok  = |h_new;
  assign diff      = (p_new >= period_q) ? (p_new - period_q) : (period_q - p_new);
  assign in_tol    = (diff <= TOL);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + ONE);
  // Saturation is reached on the edge where the counter steps onto its maximum.
  assign sat_hit   = (cnt_q == (CNT_MAX - ONE));
  assign tcnt_wrap = (tcnt_q == (h_cur - ONE));

  // Synchronize the asynchronous reference into the clk_in domain.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s2d_q <= 1'b0;
    end else begin
      s1_q  <= ref_in;
      s2_q  <= s1_q;
      s2d_q <= s2_q;
    end
  end

  // Next-state logic: disable beats rise, rise beats saturation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    period_d   = period_q;
    tcnt_d     = tcnt_q;
    clk_d      = clk_q;
    locked_d   = locked_q;
    too_fast_d = too_fast_q;
    lost_d     = 1'b0;
    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      tcnt_d   = '0;
      clk_d    = 1'b0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          if (rise) begin
            cnt_d   = '0;
            state_d = ST_MEAS;
          end
        end
        ST_MEAS, ST_RUN: begin
          if (rise) begin
            cnt_d    = '0;
            period_d = p_new;
            tcnt_d   = '0;
            if (h_new_ok) begin
              state_d    = ST_RUN;
              clk_d      = 1'b1;
              too_fast_d = 1'b0;
              // The first measured period has nothing to compare against.
              locked_d   = (state_q == ST_RUN) && in_tol;
            end else begin
              state_d    = ST_MEAS;
              clk_d      = 1'b0;
              too_fast_d = 1'b1;
              locked_d   = 1'b0;
            end
          end else if (sat_hit) begin
            lost_d   = 1'b1;
            state_d  = ST_ARM;
            clk_d    = 1'b0;
            locked_d = 1'b0;
            tcnt_d   = '0;
          end else if (state_q == ST_RUN) begin
            if (tcnt_wrap) begin
              clk_d  = ~clk_q;
              tcnt_d = '0;
            end else begin
              tcnt_d = tcnt_q + ONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      tcnt_q     <= '0;
      clk_q      <= 1'b0;
      locked_q   <= 1'b0;
      too_fast_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      tcnt_q     <= tcnt_d;
      clk_q      <= clk_d;
      locked_q   <= locked_d;
      too_fast_q <= too_fast_d;
      lost_q     <= lost_d;
    end
  end

  assign clk_out  = clk_q;
  assign period   = period_q;
  assign locked   = locked_q;
  assign too_fast = too_fast_q;
  assign lost     = lost_q;

endmodule

// File: tb/tb_clk_rate_multiplier.sv
// Bench for clk_rate_multiplier: event-level reference model feeding a scoreboard queue.
// Latency: expected outputs are pushed per edge and compared 1 time unit after that edge.
// No backpressure: every cycle produces one expected/actual pair.
module tb_clk_rate_multiplier;

  localparam int CNT_W  = 12;
  localparam int SHIFT  = 7;              // LOG2_MULT + 1
  localparam int SATVAL = (1 << CNT_W) - 1;

  logic             clk_in = 1'b0;
  logic             reset, enable, ref_in;
  logic             clk_out, locked, too_fast, lost;
  logic [CNT_W-1:0] period;

  clk_rate_multiplier #(.LOG2_MULT(6), .CNT_W(CNT_W), .LOCK_TOL(2)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .ref_in   (ref_in),
    .clk_out  (clk_out),
    .period   (period),
    .locked   (locked),
    .too_fast (too_fast),
    .lost     (lost)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit clk;
    int per;
    bit lck;
    bit tf;
    bit lst;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: phase 0 idle, 1 waiting for first rise, 2 measuring, 3 running.
  int m_phase, m_e, m_last, m_period;
  bit m_locked, m_too_fast;
  bit hist[$];

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 0; m_period = 0;
    m_locked = 0; m_too_fast = 0;
    hist = '{0, 0, 0};
  endtask

  // Advance the model by one clk_in edge using the inputs presented at that edge.
  task automatic model_step();
    exp_t x;
    bit   r;
    int   p, d, t;
    hist.push_back(ref_in);
    if (hist.size() > 8) void'(hist.pop_front());
    // A rising ref_in first sampled at edge k is acted upon at edge k+2.
    r = hist[hist.size()-3] && !hist[hist.size()-4];
    x.lst = 0;
    if (!enable) begin
      m_phase = 0; m_locked = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (r) begin m_phase = 2; m_last = m_e; end
    end else if (r) begin
      p = m_e - m_last;
      m_last = m_e;
      d = p - m_period;
      if (d < 0) d = -d;
      if ((p >> SHIFT) >= 1) begin
        m_locked   = (m_phase == 3) && (d <= 2);
        m_phase    = 3;
        m_too_fast = 0;
      end else begin
        m_locked   = 0;
        m_phase    = 2;
        m_too_fast = 1;
      end
      m_period = p;
    end else if (m_e - m_last == SATVAL) begin
      x.lst = 1; m_phase = 1; m_locked = 0;
    end
    if (m_phase == 3) begin
      t = m_e - m_last;
      x.clk = ((t / (m_period >> SHIFT)) % 2) == 0;
    end else begin
      x.clk = 0;
    end
    x.per = m_period; x.lck = m_locked; x.tf = m_too_fast;
    exp_q.push_back(x);
    m_e++;
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry after each edge.
  always @(posedge clk_in) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("clk_out", clk_out, x.clk);
      chk("period", period, x.per);
      chk("locked", locked, x.lck);
      chk("too_fast", too_fast, x.tf);
      chk("lost", lost, x.lst);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic run_ref(input int p, input int hi, input int n);
    repeat (n) begin
      ref_in = 1'b1;
      repeat (hi) tick();
      ref_in = 1'b0;
      repeat (p - hi) tick();
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_clk_out"}, clk_out, 0);
    chk({nm, "_period"}, period, 0);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_too_fast"}, too_fast, 0);
    chk({nm, "_lost"}, lost, 0);
  endtask

  initial begin
    int p, hi;
    reset = 1'b1; enable = 1'b0; ref_in = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(negedge clk_in);
    reset = 1'b0; enable = 1'b1;

    // 128-cycle reference: H = 1, locks on the third rise
    run_ref(128, 64, 6);
    chk("p128_period", period, 128);
    chk("p128_locked", locked, 1);

    // asynchronous reset in the middle of RUN
    ref_in = 1'b1;
    repeat (30) tick();
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk_in);
    reset = 1'b0;
    model_reset();
    ref_in = 1'b0;
    repeat (20) tick();

    // 1280-cycle reference: H = 10
    run_ref(1280, 640, 4);
    chk("p1280_period", period, 1280);
    chk("p1280_locked", locked, 1);

    // jitter beyond tolerance, then within tolerance
    repeat (2) begin
      run_ref(1280, 640, 1);
      run_ref(1283, 640, 1);
    end
    repeat (3) begin
      run_ref(1280, 640, 1);
      run_ref(1281, 640, 1);
    end

    // too fast, then recover at period 256
    run_ref(64, 32, 4);
    chk("p64_too_fast", too_fast, 1);
    chk("p64_clk_out", clk_out, 0);
    run_ref(256, 128, 4);
    chk("p256_too_fast", too_fast, 0);

    // enable dropped for a while, then restored
    enable = 1'b0;
    repeat (15) tick();
    enable = 1'b1;
    run_ref(300, 150, 4);

    // randomized periods and duty cycles
    repeat (8) begin
      p  = int'($urandom_range(60, 3000));
      hi = int'($urandom_range(1, p - 1));
      run_ref(p, hi, 2);
    end

    // reference stops: counter saturates, then the reference returns
    run_ref(400, 200, 3);
    ref_in = 1'b0;
    repeat (4300) tick();
    chk("stop_period", period, 400);
    chk("stop_locked", locked, 0);
    run_ref(200, 100, 5);
    chk("relock_locked", locked, 1);

    repeat (3) @(negedge clk_in);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
